alu_exec_unit: RTL and testbench

//  Multi-cycle integer execute unit; consumes the 4-bit ALUControl codes produced by ALU_Decoder.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_iter_shifter.sv | 53 +++++
 rtl/alu_exec_unit.sv | 127 ++++++++++++
 tb/tb_alu_exec_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes, execute-FSM state encoding, op classification.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_AUIPC = 4'b1000;
    localparam logic [3:0] ALU_LUI   = 4'b1001;
    localparam logic [3:0] ALU_SLL   = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;
    localparam logic [3:0] ALU_SRL   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRA) || (code == ALU_SRL);
    endfunction

    function automatic logic is_legal(input logic [3:0] code);
        return (code != 4'b0111) && (code < 4'b1101);
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative shifter: one bit position per step, direction/fill latched at load.
// Latency: N steps for shamt N; done is high during the step that applies the final shift.
// Backpressure: none; the caller only asserts step while it wants progress.
module alu_iter_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [3:0]         load_op,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [SHAMT_W-1:0] load_cnt,
    output logic [WIDTH-1:0]   acc,
    output logic [WIDTH-1:0]   step_val,
    output logic               done
);

    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q;
    logic               arith_q;

    always_comb begin
        if (left_q) begin
            step_val = {acc[WIDTH-2:0], 1'b0};
        end else begin
            step_val = {(arith_q & acc[WIDTH-1]), acc[WIDTH-1:1]};
        end
    end

    assign done = (cnt_q == SHAMT_W'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc     <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            acc     <= load_val;
            cnt_q   <= load_cnt;
            left_q  <= (load_op == ALU_SLL);
            arith_q <= (load_op == ALU_SRA);
        end else if (step) begin
            acc   <= step_val;
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage integer ALU: single-cycle ops plus bit-serial shifts behind a valid/ready handshake.
// Latency: 1 cycle for non-shift/illegal/shamt 0, N+1 for a shift by N (counting the accept edge).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (max 1 op / 2 cycles).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   shf_acc;
    logic [WIDTH-1:0]   shf_step_val;
    logic               shf_done;
    logic               shf_load;
    logic               shf_step;
    logic               accept;
    logic [SHAMT_W-1:0] shamt;

    assign shamt     = SrcB[SHAMT_W-1:0];
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_ready && in_valid;

    // Shift codes with shamt 0 fall through here as a plain pass of SrcA.
    always_comb begin
        alu_res = '0;
        case (ALUControl)
            ALU_ADD:   alu_res = SrcA + SrcB;
            ALU_SUB:   alu_res = SrcA - SrcB;
            ALU_AND:   alu_res = SrcA & SrcB;
            ALU_OR:    alu_res = SrcA | SrcB;
            ALU_XOR:   alu_res = SrcA ^ SrcB;
            ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            ALU_AUIPC: alu_res = SrcA + SrcB;
            ALU_LUI:   alu_res = SrcB;
            ALU_SLL, ALU_SRA, ALU_SRL: alu_res = SrcA;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shf_load = 1'b0;
        shf_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift(ALUControl)) begin
                        shf_load = 1'b1;
                        state_d  = (shamt != '0) ? ST_SHIFT : ST_DONE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                shf_step = 1'b1;
                if (shf_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ALUResult <= '0;
            Zero      <= 1'b1;
            illegal   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ALUResult <= alu_res;
                Zero      <= (alu_res == '0);
                illegal   <= !is_legal(ALUControl);
            end else if ((state_q == ST_SHIFT) && shf_done) begin
                ALUResult <= shf_step_val;
                Zero      <= (shf_step_val == '0);
            end
        end
    end

    alu_iter_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (shf_load),
        .step     (shf_step),
        .load_op  (ALUControl),
        .load_val (SrcA),
        .load_cnt (shamt),
        .acc      (shf_acc),
        .step_val (shf_step_val),
        .done     (shf_done)
    );

    // The final value is captured from step_val, so the accumulator itself is not observed here.
    logic unused_acc;
    assign unused_acc = ^shf_acc;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ALUControl = 4'd0;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal    (illegal)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                            input logic [31:0] b, output logic ill, output int lat);
        logic [31:0] r;
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (code)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  r = (a < b) ? 32'd1 : 32'd0;
            4'd8:  r = a + b;
            4'd9:  r = b;
            4'd10: r = a << sh;
            4'd11: r = $signed(a) >>> sh;
            4'd12: r = a >> sh;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        if (code >= 4'd10 && code <= 4'd12 && sh != 0) lat = sh + 1;
        return r;
    endfunction

    // Presents one request, waits for out_valid, and (if out_ready=1) lets it retire.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output logic ill, output int lat);
        @(negedge clk);
        in_valid = 1'b1; ALUControl = code; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        in_valid = 1'b0; ALUControl = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = ALUResult; z = Zero; ill = illegal;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALUResult !== 32'd0 || Zero !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b res=%h zero=%b ill=%b, want 1 0 0 1 0",
                     in_ready, out_valid, ALUResult, Zero, illegal);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0]  codes [10] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd11, 4'd12, 4'd10, 4'd10, 4'd7, 4'd0};
        logic [31:0] as    [10] = '{32'd5, 32'h1234, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                    32'h80000000, 32'h1, 32'h1, 32'd9, 32'd3};
        logic [31:0] bs    [10] = '{32'd7, 32'h1234, 32'd1, 32'd1, 32'd4, 32'd4, 32'h20, 32'd31, 32'd9, 32'd4};
        logic [31:0] want  [10] = '{32'd12, 32'd0, 32'd1, 32'd0, 32'hF8000000, 32'h08000000,
                                    32'h1, 32'h80000000, 32'd0, 32'd7};
        int          wlat  [10] = '{1, 1, 1, 1, 5, 5, 1, 32, 1, 1};
        logic        wil   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] res;
        logic        z, ill;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            run_op(codes[i], as[i], bs[i], res, z, ill, lat);
            checks++;
            if (res !== want[i] || z !== (want[i] == 32'd0) || ill !== wil[i] || lat != wlat[i]) begin
                errors++;
                $display("FAIL directed[%0d]: res=%h zero=%b ill=%b lat=%0d, want res=%h zero=%b ill=%b lat=%0d",
                         i, res, z, ill, lat, want[i], (want[i] == 32'd0), wil[i], wlat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        logic [3:0]  code;
        logic        z, ill, eill;
        int          lat, elat;
        for (int i = 0; i < 60; i++) begin
            code = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'd0;
            exp = ref_alu(code, a, b, eill, elat);
            run_op(code, a, b, res, z, ill, lat);
            checks++;
            if (res !== exp || z !== (exp == 32'd0) || ill !== eill || lat != elat) begin
                errors++;
                $display("FAIL random[%0d] code=%h a=%h b=%h: res=%h zero=%b ill=%b lat=%0d, want %h %b %b %0d",
                         i, code, a, b, res, z, ill, lat, exp, (exp == 32'd0), eill, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic        z, ill;
        int          lat;
        out_ready = 1'b0;
        run_op(4'd1, 32'd100, 32'd1, res, z, ill, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; ALUControl = 4'd0; SrcA = $urandom; SrcB = $urandom;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== 32'd99) begin
                errors++;
                $display("FAIL backpressure hold[%0d]: out_valid=%b in_ready=%b res=%h, want 1 0 00000063",
                         i, out_valid, in_ready, ALUResult);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'd99) begin
            errors++;
            $display("FAIL backpressure release: out_valid=%b in_ready=%b res=%h, want 0 1 00000063",
                     out_valid, in_ready, ALUResult);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] res;
        logic        z, ill;
        int          lat;
        @(negedge clk);
        in_valid = 1'b1; ALUControl = 4'd10; SrcA = 32'hDEADBEEF; SrcB = 32'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid-shift busy: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
        end
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Zero !== 1'b1 || ALUResult !== 32'd0) begin
            errors++;
            $display("FAIL reset mid-shift: out_valid=%b in_ready=%b zero=%b res=%h, want 0 1 1 0",
                     out_valid, in_ready, Zero, ALUResult);
        end
        @(negedge clk); reset_n = 1'b1;
        run_op(4'd12, 32'hF0000000, 32'd3, res, z, ill, lat);
        checks++;
        if (res !== 32'h1E000000 || lat != 4 || ill !== 1'b0) begin
            errors++;
            $display("FAIL post-reset srl: res=%h lat=%0d ill=%b, want 1e000000 4 0", res, lat, ill);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
